// File: rtl/dmem_lsu.sv
// Single-port 32-bit data memory with byte/half/word load-store and WAIT_CYCLES wait states.
// Define DMEM_MISALIGN_CHK_EN to fault misaligned halves/words and the reserved size encoding.
module dmem_lsu #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  // state | meaning
  // IDLE  | ready, waiting for a request
  // WAIT  | counting down wait states
  // RESP  | one-cycle response pulse
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic              lat_unsigned;
  logic [1:0]        lat_size;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [2**ADDR_W];

  logic              accept;
  logic              access;
  logic              a_we;
  logic              a_unsigned;
  logic [1:0]        a_size;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic              fault;
  logic [31:0]       wmask;
  logic [31:0]       wshift;
  logic [31:0]       word;
  logic [31:0]       shifted;
  logic [31:0]       ld_data;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the accept edge itself, straight from the inputs.
  assign access = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd1));

  assign a_we       = (state == IDLE) ? req_we       : lat_we;
  assign a_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
  assign a_size     = (state == IDLE) ? req_size     : lat_size;
  assign a_addr     = (state == IDLE) ? req_addr[ADDR_W+1:0] : lat_addr;
  assign a_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

  assign idx = a_addr[ADDR_W+1:2];

  always_comb begin
    fault = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    case (a_size)
      2'b01:   fault = a_addr[0];
      2'b10:   fault = |a_addr[1:0];
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
`endif
  end

  // Sub-word lane selection; misaligned low bits are dropped for halves and words.
  always_comb begin
    lane = 2'b00;
    be   = 4'b1111;
    case (a_size)
      2'b00: begin
        lane = a_addr[1:0];
        be   = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        lane = {a_addr[1], 1'b0};
        be   = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane = 2'b00;
        be   = 4'b1111;
      end
    endcase
  end

  assign wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wshift  = a_wdata << {lane, 3'b000};
  assign word    = mem[idx];
  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    case (a_size)
      2'b00:   ld_data = {{24{shifted[7] & ~a_unsigned}}, shifted[7:0]};
      2'b01:   ld_data = {{16{shifted[15] & ~a_unsigned}}, shifted[15:0]};
      default: ld_data = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && a_we && !fault) begin
      mem[idx] <= (word & ~wmask) | (wshift & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
    end else begin
      rsp_valid <= access;
      rsp_rdata <= (access && !a_we && !fault) ? ld_data : 32'd0;
      rsp_err   <= access && fault;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_addr     <= req_addr[ADDR_W+1:0];
            lat_wdata    <= req_wdata;
            cnt          <= 4'(WAIT_CYCLES);
            state        <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (0, 3 and 2 wait states) checked every cycle
// against a byte-array memory model plus literal expectations for key accesses.
module tb_dmem_lsu;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [N];
  logic        req_valid    [N];
  logic        req_ready    [N];
  logic        req_we       [N];
  logic [1:0]  req_size     [N];
  logic        req_unsigned [N];
  logic [31:0] req_addr     [N];
  logic [31:0] req_wdata    [N];
  logic        rsp_valid    [N];
  logic [31:0] rsp_rdata    [N];
  logic        rsp_err      [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    dmem_lsu #(.ADDR_W(8), .WAIT_CYCLES(W)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  function automatic int wc(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 2;
  endfunction

  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  bit          pend    [N];
  int          acc     [N];
  int          due     [N];
  logic [31:0] exp_rd  [N];
  logic        exp_er  [N];
  bit          pw_en   [N];
  int          pw_base [N];
  int          pw_n    [N];
  logic [31:0] pw_data [N];
  logic [7:0]  mem_m   [N][1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %08h required %08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Per-cycle comparison against the model; a store's bytes land in the model when its response is due.
  always @(negedge clk) begin : cmp
    logic ev;
    logic er;
    for (int i = 0; i < N; i++) begin
      ev = pend[i] && (cyc == due[i]);
      er = rst_n[i] && !(pend[i] && cyc >= acc[i] && cyc <= due[i]);
      chk($sformatf("ready[%0d]", i), 32'(req_ready[i]), 32'(er));
      chk($sformatf("valid[%0d]", i), 32'(rsp_valid[i]), 32'(ev));
      chk($sformatf("rdata[%0d]", i), rsp_rdata[i], ev ? exp_rd[i] : 32'd0);
      chk($sformatf("err[%0d]", i), 32'(rsp_err[i]), ev ? 32'(exp_er[i]) : 32'd0);
      if (ev) begin
        if (pw_en[i])
          for (int b = 0; b < pw_n[i]; b++) mem_m[i][pw_base[i] + b] = pw_data[i][8*b +: 8];
        pend[i] = 1'b0;
      end
    end
  end

  task automatic drive(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz;
    req_unsigned[i] = uns; req_addr[i] = a; req_wdata[i] = wd;
  endtask

  // Model of one access, called in the cycle the request is presented (accepted on the next edge).
  task automatic model_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    logic [31:0] v;
    logic er;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
    base = int'(a[9:0]) & ~(n - 1);
    v = 32'd0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = mem_m[i][base + b];
    if (n < 4 && !uns && v[8*n-1])
      for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
    acc[i]     = cyc + 1;
    due[i]     = cyc + 1 + wc(i);
    exp_er[i]  = er;
    exp_rd[i]  = (we || er) ? 32'd0 : v;
    pw_en[i]   = we && !er;
    pw_base[i] = base;
    pw_n[i]    = n;
    pw_data[i] = wd;
    pend[i]    = 1'b1;
  endtask

  task automatic issue(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold,
                       input logic [31:0] lit, input logic lit_err);
    @(negedge clk); #1;
    drive(i, we, sz, uns, a, wd);
    model_req(i, we, sz, uns, a, wd);
    chk("model_rdata", exp_rd[i], lit);
    chk("model_err", 32'(exp_er[i]), 32'(lit_err));
    @(negedge clk);
    // Keep valid high with a different store while busy; it must be ignored.
    if (hold) begin
      #1;
      req_we[i] = 1'b1; req_size[i] = 2'd2; req_addr[i] = a + 32'd4; req_wdata[i] = 32'hBAD0BAD0;
    end
    repeat (wc(i)) @(negedge clk);
    chk("lit_valid", 32'(rsp_valid[i]), 32'd1);
    chk("lit_rdata", rsp_rdata[i], lit);
    chk("lit_err", 32'(rsp_err[i]), 32'(lit_err));
    #1 req_valid[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
      req_unsigned[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // No wait states: extraction and extension.
    issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    issue(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0);
    issue(0, 0, 2'd0, 1, 32'h13, 32'h0, 0, 32'h000000DE, 0);
    issue(0, 0, 2'd1, 1, 32'h12, 32'h0, 0, 32'h0000DEAD, 0);
    issue(0, 0, 2'd1, 0, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 0);
    issue(0, 0, 2'd0, 0, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 0);
    issue(0, 1, 2'd1, 0, 32'h10, 32'h00001234, 0, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEAD1234, 0);
    issue(0, 1, 2'd0, 0, 32'h11, 32'h00000077, 0, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEAD7734, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    issue(0, 1, 2'd2, 0, 32'h11, 32'h11223344, 0, 32'h0, 1);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEAD7734, 0);
`else
    issue(0, 1, 2'd2, 0, 32'h11, 32'h11223344, 0, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h11223344, 0);
`endif
    issue(0, 1, 2'd2, 0, 32'h400, 32'hCAFEF00D, 0, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 32'hCAFEF00D, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    issue(0, 0, 2'd3, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    issue(0, 0, 2'd1, 0, 32'h3, 32'h0, 0, 32'h0, 1);
`else
    issue(0, 0, 2'd3, 0, 32'h0, 32'h0, 0, 32'hCAFEF00D, 0);
    issue(0, 0, 2'd1, 0, 32'h3, 32'h0, 0, 32'hFFFFCAFE, 0);
`endif

    // Three wait states, with the request held and altered while busy.
    issue(1, 1, 2'd2, 0, 32'h24, 32'h55AA55AA, 0, 32'h0, 0);
    issue(1, 1, 2'd2, 0, 32'h20, 32'h12345678, 1, 32'h0, 0);
    issue(1, 0, 2'd2, 0, 32'h24, 32'h0, 0, 32'h55AA55AA, 0);
    issue(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h12345678, 0);
    issue(1, 0, 2'd0, 0, 32'h21, 32'h0, 0, 32'h00000056, 0);

    // Two wait states, store aborted by reset during WAIT.
    issue(2, 1, 2'd2, 0, 32'h30, 32'hA5A5A5A5, 0, 32'h0, 0);
    @(negedge clk); #1;
    drive(2, 1, 2'd2, 0, 32'h30, 32'h0F0F0F0F);
    model_req(2, 1, 2'd2, 0, 32'h30, 32'h0F0F0F0F);
    @(negedge clk); #1;
    req_valid[2] = 1'b0;
    rst_n[2] = 1'b0;
    pend[2] = 1'b0;
    #1;
    chk("rst_ready_low", 32'(req_ready[2]), 32'd0);
    chk("rst_valid_low", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk); #1;
    rst_n[2] = 1'b1;
    #1;
    chk("ready_after_rst", 32'(req_ready[2]), 32'd1);
    repeat (4) @(negedge clk);
    issue(2, 0, 2'd2, 0, 32'h30, 32'h0, 0, 32'hA5A5A5A5, 0);
    issue(2, 1, 2'd2, 0, 32'h30, 32'h0F0F0F0F, 0, 32'h0, 0);
    issue(2, 0, 2'd2, 0, 32'h30, 32'h0, 0, 32'h0F0F0F0F, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
